// File: rtl/bram_pkg.sv
// Shared constants, clear FSM state encoding and width helper for bram_dp.
package bram_pkg;

    localparam int RDW_OLD = 0;
    localparam int RDW_NEW = 1;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } clr_state_e;

    function automatic int bytes_per_word(input int data_width);
        return data_width / 8;
    endfunction

endpackage

// File: rtl/bram_dp_if.sv
// Write/read/clear bus for bram_dp; master drives requests, slave returns data.
interface bram_dp_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
);
    import bram_pkg::*;

    localparam int BE_WIDTH = bytes_per_word(DATA_WIDTH);

    logic                  i_we;
    logic [BE_WIDTH-1:0]   i_be;
    logic [ADDR_WIDTH-1:0] i_waddr;
    logic [DATA_WIDTH-1:0] i_di;
    logic                  i_re;
    logic [ADDR_WIDTH-1:0] i_raddr;
    logic                  i_clr;
    logic [DATA_WIDTH-1:0] o_dout;
    logic                  o_dvalid;
    logic                  o_busy;

    modport master (
        output i_we, i_be, i_waddr, i_di, i_re, i_raddr, i_clr,
        input  o_dout, o_dvalid, o_busy
    );

    modport slave (
        input  i_we, i_be, i_waddr, i_di, i_re, i_raddr, i_clr,
        output o_dout, o_dvalid, o_busy
    );

endinterface

// File: rtl/bram_clr_fsm.sv
// Clear engine: walks every address once, emitting a zero-write per cycle.
//
//   state    | meaning
//   ---------+--------------------------------------------------
//   ST_IDLE  | normal operation, waiting for a clear request
//   ST_CLEAR | zeroing word[cnt_q]; returns to IDLE after DEPTH-1
module bram_clr_fsm
    import bram_pkg::*;
#(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  i_rst_n,
    input  logic                  i_clr,
    output logic                  o_busy,
    output logic                  o_clr_we,
    output logic [ADDR_WIDTH-1:0] o_clr_addr
);

    clr_state_e            state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;

    // State and counter registers; reset aborts any clear in progress.
    always_ff @(posedge clk) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and clear-write generation.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        o_clr_we   = 1'b0;
        o_clr_addr = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (i_clr) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                end
            end
            ST_CLEAR: begin
                o_clr_we = 1'b1;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == {ADDR_WIDTH{1'b1}}) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign o_busy = (state_q == ST_CLEAR);

endmodule

// File: rtl/bram_dp.sv
// Simple-dual-port block RAM with byte-enabled writes, 1/2-cycle registered
// reads, selectable read-during-write result and a full-array clear engine.
module bram_dp
    import bram_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 8,
    parameter int READ_LATENCY = 1,
    parameter int RDW_MODE     = RDW_OLD
) (
    input  logic     clk,
    input  logic     i_rst_n,
    bram_dp_if.slave bus
);

    localparam int NUM_BYTES = bytes_per_word(DATA_WIDTH);
    localparam int DEPTH     = 2 ** ADDR_WIDTH;

    if (DATA_WIDTH % 8 != 0) begin : g_bad_width
        $error("bram_dp: DATA_WIDTH must be a multiple of 8");
    end
    if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
        $error("bram_dp: READ_LATENCY must be 1 or 2");
    end

    logic                  busy;
    logic                  clr_we;
    logic [ADDR_WIDTH-1:0] clr_addr;
    logic                  accept;
    logic                  wr_en;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] be_mask;
    logic [DATA_WIDTH-1:0] rd_old;
    logic [DATA_WIDTH-1:0] rd_word;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] s1_data_q;
    logic                  s1_valid_q;

    bram_clr_fsm #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_clr_fsm (
        .clk        (clk),
        .i_rst_n    (i_rst_n),
        .i_clr      (bus.i_clr),
        .o_busy     (busy),
        .o_clr_we   (clr_we),
        .o_clr_addr (clr_addr)
    );

    // A clear request in IDLE swallows any write/read offered in the same cycle.
    assign accept = !busy && !bus.i_clr;
    assign wr_en  = accept && bus.i_we;
    assign rd_en  = accept && bus.i_re;

    // Expand byte enables into a bit mask for the read-during-write merge.
    always_comb begin
        be_mask = '0;
        for (int k = 0; k < NUM_BYTES; k++) begin
            be_mask[8*k +: 8] = {8{bus.i_be[k]}};
        end
    end

    // Select the word entering the read pipeline, forwarding merged write data if enabled.
    always_comb begin
        rd_old  = mem_q[bus.i_raddr];
        rd_word = rd_old;
        if (RDW_MODE == RDW_NEW && wr_en && bus.i_waddr == bus.i_raddr) begin
            rd_word = (rd_old & ~be_mask) | (bus.i_di & be_mask);
        end
    end

    // Array write port: clear writes take priority, user writes merge per byte.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem_q[clr_addr] <= '0;
        end else if (wr_en) begin
            for (int k = 0; k < NUM_BYTES; k++) begin
                if (bus.i_be[k]) begin
                    mem_q[bus.i_waddr][8*k +: 8] <= bus.i_di[8*k +: 8];
                end
            end
        end
    end

    // First read stage; its data holds when no read is issued.
    always_ff @(posedge clk) begin
        if (!i_rst_n) begin
            s1_data_q  <= '0;
            s1_valid_q <= 1'b0;
        end else begin
            s1_valid_q <= rd_en;
            if (rd_en) begin
                s1_data_q <= rd_word;
            end
        end
    end

    if (READ_LATENCY == 1) begin : g_lat1
        assign bus.o_dout   = s1_data_q;
        assign bus.o_dvalid = s1_valid_q;
    end else begin : g_lat2
        logic [DATA_WIDTH-1:0] s2_data_q;
        logic                  s2_valid_q;

        // Second read stage; drains independently of the clear engine.
        always_ff @(posedge clk) begin
            if (!i_rst_n) begin
                s2_data_q  <= '0;
                s2_valid_q <= 1'b0;
            end else begin
                s2_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    s2_data_q <= s1_data_q;
                end
            end
        end

        assign bus.o_dout   = s2_data_q;
        assign bus.o_dvalid = s2_valid_q;
    end

    assign bus.o_busy = busy;

endmodule

// File: tb/tb_bram_dp.sv
// Directed bench for bram_dp: two instances share stimulus, one with
// 1-cycle latency / old-data RDW and one with 2-cycle latency / new-data RDW.
module tb_bram_dp;
    import bram_pkg::*;

    localparam int DW = 32;
    localparam int AW = 8;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    bram_dp_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus1 ();
    bram_dp_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus2 ();

    bram_dp #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(1), .RDW_MODE(RDW_OLD)
    ) u_dut1 (
        .clk     (clk),
        .i_rst_n (rst_n),
        .bus     (bus1)
    );

    bram_dp #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(2), .RDW_MODE(RDW_NEW)
    ) u_dut2 (
        .clk     (clk),
        .i_rst_n (rst_n),
        .bus     (bus2)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic we, input logic [3:0] be, input logic [7:0] waddr,
                         input logic [31:0] di, input logic re, input logic [7:0] raddr,
                         input logic clr);
        bus1.i_we = we; bus1.i_be = be; bus1.i_waddr = waddr; bus1.i_di = di;
        bus1.i_re = re; bus1.i_raddr = raddr; bus1.i_clr = clr;
        bus2.i_we = we; bus2.i_be = be; bus2.i_waddr = waddr; bus2.i_di = di;
        bus2.i_re = re; bus2.i_raddr = raddr; bus2.i_clr = clr;
    endtask

    task automatic idle_in;
        drive(1'b0, 4'h0, 8'h00, 32'h0, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic write_word(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] be);
        drive(1'b1, be, addr, data, 1'b0, 8'h00, 1'b0);
        tick;
        idle_in;
    endtask

    task automatic fill_all(input logic [31:0] data);
        for (int i = 0; i < 256; i++) begin
            drive(1'b1, 4'hF, 8'(i), data, 1'b0, 8'h00, 1'b0);
            tick;
        end
        idle_in;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        idle_in;
        tick;
        tick;
        if (bus1.o_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy1: got %b want 0", bus1.o_busy); end
        n_checks++;
        if (bus2.o_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy2: got %b want 0", bus2.o_busy); end
        n_checks++;
        if (bus1.o_dvalid !== 1'b0) begin n_fail++; $display("FAIL reset_dvalid1: got %b want 0", bus1.o_dvalid); end
        n_checks++;
        if (bus2.o_dvalid !== 1'b0) begin n_fail++; $display("FAIL reset_dvalid2: got %b want 0", bus2.o_dvalid); end
        n_checks++;
        if (bus1.o_dout !== 32'h0) begin n_fail++; $display("FAIL reset_dout1: got %h want 0", bus1.o_dout); end
        n_checks++;
        if (bus2.o_dout !== 32'h0) begin n_fail++; $display("FAIL reset_dout2: got %h want 0", bus2.o_dout); end
        n_checks++;
        rst_n = 1'b1;
        tick;
    endtask

    task automatic test_byte_merge;
        write_word(8'h10, 32'hAABBCCDD, 4'b1111);
        write_word(8'h10, 32'h11223344, 4'b0101);
        write_word(8'h10, 32'h00000000, 4'b0000);
        drive(1'b0, 4'h0, 8'h00, 32'h0, 1'b1, 8'h10, 1'b0);
        tick;
        idle_in;
        if (bus1.o_dvalid !== 1'b1 || bus1.o_dout !== 32'hAA22CC44) begin
            n_fail++; $display("FAIL merge_lat1: got v=%b d=%h want v=1 d=aa22cc44", bus1.o_dvalid, bus1.o_dout);
        end
        n_checks++;
        if (bus2.o_dvalid !== 1'b0) begin n_fail++; $display("FAIL merge_lat2_early: got v=%b want 0", bus2.o_dvalid); end
        n_checks++;
        tick;
        if (bus2.o_dvalid !== 1'b1 || bus2.o_dout !== 32'hAA22CC44) begin
            n_fail++; $display("FAIL merge_lat2: got v=%b d=%h want v=1 d=aa22cc44", bus2.o_dvalid, bus2.o_dout);
        end
        n_checks++;
        if (bus1.o_dvalid !== 1'b0 || bus1.o_dout !== 32'hAA22CC44) begin
            n_fail++; $display("FAIL merge_hold1: got v=%b d=%h want v=0 d=aa22cc44", bus1.o_dvalid, bus1.o_dout);
        end
        n_checks++;
    endtask

    task automatic test_rdw;
        write_word(8'h03, 32'h00000005, 4'hF);
        drive(1'b1, 4'hF, 8'h03, 32'h00000009, 1'b1, 8'h03, 1'b0);
        tick;
        idle_in;
        if (bus1.o_dvalid !== 1'b1 || bus1.o_dout !== 32'h5) begin
            n_fail++; $display("FAIL rdw_old: got v=%b d=%h want v=1 d=5", bus1.o_dvalid, bus1.o_dout);
        end
        n_checks++;
        tick;
        if (bus2.o_dvalid !== 1'b1 || bus2.o_dout !== 32'h9) begin
            n_fail++; $display("FAIL rdw_new: got v=%b d=%h want v=1 d=9", bus2.o_dvalid, bus2.o_dout);
        end
        n_checks++;
        drive(1'b0, 4'h0, 8'h00, 32'h0, 1'b1, 8'h03, 1'b0);
        tick;
        idle_in;
        if (bus1.o_dout !== 32'h9) begin n_fail++; $display("FAIL rdw_after1: got %h want 9", bus1.o_dout); end
        n_checks++;
        tick;
        if (bus2.o_dout !== 32'h9) begin n_fail++; $display("FAIL rdw_after2: got %h want 9", bus2.o_dout); end
        n_checks++;
    endtask

    task automatic test_back_to_back;
        int v2count;
        v2count = 0;
        for (int i = 0; i < 8; i++) write_word(8'(i), 32'(i), 4'hF);
        for (int k = 0; k < 10; k++) begin
            if (k < 8) drive(1'b0, 4'h0, 8'h00, 32'h0, 1'b1, 8'(k), 1'b0);
            else       idle_in;
            tick;
            if (bus1.o_dvalid !== (k < 8)) begin
                n_fail++; $display("FAIL b2b_valid1[%0d]: got %b want %b", k, bus1.o_dvalid, (k < 8));
            end
            n_checks++;
            if (k < 8) begin
                if (bus1.o_dout !== 32'(k)) begin n_fail++; $display("FAIL b2b_data1[%0d]: got %h want %h", k, bus1.o_dout, k); end
                n_checks++;
            end
            if (bus2.o_dvalid !== (k >= 1 && k <= 8)) begin
                n_fail++; $display("FAIL b2b_valid2[%0d]: got %b want %b", k, bus2.o_dvalid, (k >= 1 && k <= 8));
            end
            n_checks++;
            if (k >= 1 && k <= 8) begin
                if (bus2.o_dout !== 32'(k - 1)) begin n_fail++; $display("FAIL b2b_data2[%0d]: got %h want %h", k, bus2.o_dout, k - 1); end
                n_checks++;
            end
            if (bus2.o_dvalid === 1'b1) v2count++;
        end
        if (v2count !== 8) begin n_fail++; $display("FAIL b2b_count2: got %0d want 8", v2count); end
        n_checks++;
    endtask

    task automatic test_clear;
        int busy_cycles;
        fill_all(32'hFFFFFFFF);
        drive(1'b1, 4'hF, 8'h05, 32'h12345678, 1'b1, 8'h05, 1'b1);
        tick;
        busy_cycles = 0;
        for (int c = 0; c < 300 && bus1.o_busy === 1'b1; c++) begin
            busy_cycles++;
            if (bus1.o_dvalid !== 1'b0 || bus2.o_dvalid !== 1'b0) begin
                n_fail++; $display("FAIL clear_dvalid[%0d]: got %b/%b want 0/0", c, bus1.o_dvalid, bus2.o_dvalid);
            end
            n_checks++;
            drive(1'b1, 4'hF, 8'h00, 32'hFFFFFFFF, 1'b1, 8'h00, (c >= 10 && c < 20));
            tick;
        end
        if (busy_cycles !== 256) begin n_fail++; $display("FAIL clear_busy_len: got %0d want 256", busy_cycles); end
        n_checks++;
        if (bus2.o_busy !== 1'b0) begin n_fail++; $display("FAIL clear_busy2_end: got %b want 0", bus2.o_busy); end
        n_checks++;
        if (bus1.o_dvalid !== 1'b0 || bus2.o_dvalid !== 1'b0) begin
            n_fail++; $display("FAIL clear_end_dvalid: got %b/%b want 0/0", bus1.o_dvalid, bus2.o_dvalid);
        end
        n_checks++;
        for (int a = 0; a < 256; a++) begin
            drive(1'b0, 4'h0, 8'h00, 32'h0, 1'b1, 8'(a), 1'b0);
            tick;
            if (bus1.o_dvalid !== 1'b1 || bus1.o_dout !== 32'h0) begin
                n_fail++; $display("FAIL clear_word[%0d]: got v=%b d=%h want v=1 d=0", a, bus1.o_dvalid, bus1.o_dout);
            end
            n_checks++;
        end
        idle_in;
        tick;
        tick;
    endtask

    task automatic test_reset_mid_clear;
        logic [7:0]  addrs [6];
        logic [31:0] exps  [6];
        addrs = '{8'd0, 8'd50, 8'd97, 8'd101, 8'd200, 8'd255};
        exps  = '{32'h0, 32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
        fill_all(32'hFFFFFFFF);
        drive(1'b0, 4'h0, 8'h00, 32'h0, 1'b0, 8'h00, 1'b1);
        tick;
        idle_in;
        for (int c = 1; c < 100; c++) tick;
        if (bus1.o_busy !== 1'b1) begin n_fail++; $display("FAIL midclr_busy_before: got %b want 1", bus1.o_busy); end
        n_checks++;
        rst_n = 1'b0;
        tick;
        if (bus1.o_busy !== 1'b0 || bus2.o_busy !== 1'b0) begin
            n_fail++; $display("FAIL midclr_busy: got %b/%b want 0/0", bus1.o_busy, bus2.o_busy);
        end
        n_checks++;
        if (bus1.o_dvalid !== 1'b0 || bus2.o_dvalid !== 1'b0) begin
            n_fail++; $display("FAIL midclr_dvalid: got %b/%b want 0/0", bus1.o_dvalid, bus2.o_dvalid);
        end
        n_checks++;
        if (bus1.o_dout !== 32'h0 || bus2.o_dout !== 32'h0) begin
            n_fail++; $display("FAIL midclr_dout: got %h/%h want 0/0", bus1.o_dout, bus2.o_dout);
        end
        n_checks++;
        rst_n = 1'b1;
        tick;
        if (bus1.o_busy !== 1'b0) begin n_fail++; $display("FAIL midclr_busy_after: got %b want 0", bus1.o_busy); end
        n_checks++;
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, 4'h0, 8'h00, 32'h0, 1'b1, addrs[i], 1'b0);
            tick;
            idle_in;
            if (bus1.o_dout !== exps[i]) begin
                n_fail++; $display("FAIL midclr_word[%0d]: got %h want %h", addrs[i], bus1.o_dout, exps[i]);
            end
            n_checks++;
            tick;
        end
    endtask

    task automatic test_idle_reset;
        write_word(8'h20, 32'hDEADBEEF, 4'hF);
        drive(1'b0, 4'h0, 8'h00, 32'h0, 1'b1, 8'h20, 1'b0);
        tick;
        idle_in;
        tick;
        if (bus1.o_dout !== 32'hDEADBEEF || bus2.o_dout !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL idlerst_pre: got %h/%h want deadbeef", bus1.o_dout, bus2.o_dout);
        end
        n_checks++;
        rst_n = 1'b0;
        tick;
        if (bus1.o_dout !== 32'h0 || bus2.o_dout !== 32'h0) begin
            n_fail++; $display("FAIL idlerst_dout: got %h/%h want 0/0", bus1.o_dout, bus2.o_dout);
        end
        n_checks++;
        rst_n = 1'b1;
        drive(1'b0, 4'h0, 8'h00, 32'h0, 1'b1, 8'h20, 1'b0);
        tick;
        idle_in;
        if (bus1.o_dout !== 32'hDEADBEEF) begin n_fail++; $display("FAIL idlerst_keep1: got %h want deadbeef", bus1.o_dout); end
        n_checks++;
        tick;
        if (bus2.o_dout !== 32'hDEADBEEF) begin n_fail++; $display("FAIL idlerst_keep2: got %h want deadbeef", bus2.o_dout); end
        n_checks++;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        idle_in;
        test_reset;
        test_byte_merge;
        test_rdw;
        test_back_to_back;
        test_clear;
        test_reset_mid_clear;
        test_idle_reset;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bram_dp.md
# bram_dp

- Parametrised simple-dual-port block RAM; successor to the CPU core's byte-wide BRAM.
- One write port with per-byte enables and one read port; data width and depth are configurable.
- Read latency is selectable (1 or 2 cycles) and read-during-write behaviour is selectable; reads return a valid strobe.
- A hardware clear engine zeroes the whole array on request.
- Used for instruction/data memories and debug buffers in the CPU core.

## Interface
- DATA_WIDTH, 32, word width in bits; must be a multiple of 8 (elaboration error otherwise)
- ADDR_WIDTH, 8, address width; DEPTH = 2**ADDR_WIDTH words
- READ_LATENCY, 1, 1 or 2 cycles from i_re edge to data; any other value is an elaboration error
- RDW_MODE, 0, same-address read during write: 0 = old data, 1 = new data
- clk  in  1  clock; all logic on rising edge
- i_rst_n  in  1  synchronous, active-low reset
- i_we  in  1  write request
- i_be  in  DATA_WIDTH/8  byte enables; bit k selects i_di[8k+7:8k]
- i_waddr  in  ADDR_WIDTH  write address
- i_di  in  DATA_WIDTH  write data
- i_re  in  1  read request
- i_raddr  in  ADDR_WIDTH  read address
- i_clr  in  1  start full-array clear (single-cycle pulse or level)
- o_dout  out  DATA_WIDTH  read data
- o_dvalid  out  1  o_dout holds the result of a read issued READ_LATENCY cycles earlier
- o_busy  out  1  clear in progress

## Operation
- Storage: DEPTH x DATA_WIDTH array, block-RAM inferred.
  - Simulation initial contents are all zero.
  - Reset does not alter array contents.
- Write (IDLE, i_we=1): for each k with i_be[k]=1, byte k of word i_waddr takes i_di byte k. Other bytes are unchanged. i_be=0 is a no-op.
- Read (IDLE, i_re=1): word i_raddr enters the read pipeline.
  - o_dout and o_dvalid update READ_LATENCY cycles later.
  - Without a read, o_dvalid=0 and o_dout holds its last value.
- Read-during-write at the same address:
  - RDW_MODE=0 returns the pre-write word.
  - RDW_MODE=1 returns the merged word: enabled bytes from i_di, the rest old.
- Clear FSM, states IDLE and CLEAR:
  - IDLE -> CLEAR on i_clr=1. Clear counter loads 0 and o_busy=1 from the next cycle.
  - CLEAR: writes zero to word[counter] each cycle and increments the counter. When counter = DEPTH-1 that word is written and the FSM returns to IDLE. The clear takes DEPTH cycles with o_busy=1.
  - In CLEAR, i_we, i_re and i_clr are ignored: no writes, o_dvalid stays 0 for those cycles, no restart.
  - IDLE with i_clr and i_we in the same cycle: the clear wins and the write is dropped. A simultaneous i_re is dropped as well.
- Reads already in the 2-stage pipeline when a clear starts still complete with their captured data.

## Timing
- Reset (i_rst_n=0 at an edge) sets o_dout=0, o_dvalid=0, o_busy=0, FSM to IDLE, clear counter to 0, and clears pipeline valid bits.
- Reset during CLEAR aborts it: the array is left partially cleared, o_busy=0 after that edge.
- Write latency: data is visible to a read issued on the following edge.
- READ_LATENCY=1: i_re sampled at edge N gives o_dout/o_dvalid valid after edge N. READ_LATENCY=2: valid after edge N+1.
- Back-to-back reads give one result per cycle, with o_dvalid high continuously.
- o_busy rises one cycle after i_clr and falls after the final clear write. The next i_we or i_re is accepted in the cycle o_busy=0.

## Structure
- Package bram_pkg holds:
  - RDW_OLD=0 and RDW_NEW=1 constants;
  - the clear FSM state encoding (ST_IDLE, ST_CLEAR);
  - a function returning DATA_WIDTH/8.
- Sub-module bram_clr_fsm: the clear state machine, counter and o_busy, outputting the clear write enable and address. The array, byte-merge and read pipeline stay in bram_dp.

## Test plan
- Byte-enable merge: write 0xAABBCCDD to addr 0x10 with i_be=4'b1111, then 0x11223344 with i_be=4'b0101, then read 0x10 -> 0xAA22CC44, o_dvalid after READ_LATENCY.
- RDW: preload 0x00000005 at addr 3; same cycle write 0x00000009 (be=all) and read addr 3 -> RDW_MODE=0 returns 0x5, RDW_MODE=1 returns 0x9; next read returns 0x9.
- Latency/throughput: READ_LATENCY=2, reads of addr 0..7 on consecutive cycles (contents = addr) -> o_dout 0..7 starting 2 cycles after first i_re, o_dvalid high 8 cycles.
- Clear: fill with 0xFFFFFFFF, pulse i_clr together with i_we -> o_busy high exactly 256 cycles (ADDR_WIDTH=8), reads/writes during busy ignored (o_dvalid=0), all addresses read 0 afterwards.
- Reset mid-clear: i_rst_n=0 at cycle 100 of clear -> o_busy=0, o_dvalid=0, o_dout=0; words 0..~99 zero, upper words still 0xFFFFFFFF.
- Idle reset: o_dout=0xDEADBEEF before reset -> o_dout=0 after reset edge, array contents preserved.
